// File: rtl/ram_ctrl_pkg.sv
// Shared types and per-state strobe table for the RISC-Y RAM access controller.
// The FSM registers the strobe word of the state it is entering.
package ram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_SAMPLE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_DONE
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic cs;     // RAM read enable
        logic oe;     // RAM write enable
        logic ws;     // write strobe
        logic drive;  // controller drives DATA
        logic busy;
    } strobe_t;

    localparam strobe_t STB_IDLE = '{cs: 1'b0, oe: 1'b0, ws: 1'b0, drive: 1'b0, busy: 1'b0};
    localparam strobe_t STB_READ = '{cs: 1'b1, oe: 1'b0, ws: 1'b0, drive: 1'b0, busy: 1'b1};
    localparam strobe_t STB_WSET = '{cs: 1'b0, oe: 1'b1, ws: 1'b0, drive: 1'b1, busy: 1'b1};
    localparam strobe_t STB_WSTB = '{cs: 1'b0, oe: 1'b1, ws: 1'b1, drive: 1'b1, busy: 1'b1};
    localparam strobe_t STB_DONE = '{cs: 1'b0, oe: 1'b0, ws: 1'b0, drive: 1'b0, busy: 1'b1};

    function automatic strobe_t strobes_of(input state_e s);
        strobe_t r;
        r = STB_IDLE;
        case (s)
            ST_RD_ADDR,
            ST_RD_SAMPLE: r = STB_READ;
            ST_WR_SETUP:  r = STB_WSET;
            ST_WR_STROBE,
            ST_WR_HOLD:   r = STB_WSTB;
            ST_DONE:      r = STB_DONE;
            default:      r = STB_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant flop resets to port B so A wins first.
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic en_i,
    output logic grant_o,
    output logic port_o
);

    logic last_q;

    always_comb begin
        grant_o = en_i & (req_a_i | req_b_i);
        if (req_a_i && req_b_i) begin
            port_o = (last_q == PORT_B) ? PORT_A : PORT_B;
        end else if (req_b_i) begin
            port_o = PORT_B;
        end else begin
            port_o = PORT_A;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_q <= PORT_B;
        end else if (grant_o) begin
            last_q <= port_o;
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Two-port sequencer/arbiter in front of the shared RAM; owns the controller side of DATA.
// All strobes are registered from the next state, so they are valid for the whole state.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [AWIDTH-1:0] A_ADDR,
    input  logic [WIDTH-1:0]  A_WDATA,
    output logic [WIDTH-1:0]  A_RDATA,
    output logic              A_DONE,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [AWIDTH-1:0] B_ADDR,
    input  logic [WIDTH-1:0]  B_WDATA,
    output logic [WIDTH-1:0]  B_RDATA,
    output logic              B_DONE,
    output logic [AWIDTH-1:0] ADDR,
    output logic              RAM_CS,
    output logic              RAM_OE,
    output logic              WS,
    inout  wire  [WIDTH-1:0]  DATA,
    output logic              BUSY
);

    state_e            state_q, state_d;
    strobe_t           stb_d;
    logic              grant, gnt_port;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;

    logic              port_q;
    logic [AWIDTH-1:0] addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  a_rdata_q, b_rdata_q;
    logic              cs_q, oe_q, ws_q, drive_q, busy_q;
    logic              a_done_q, b_done_q;

    rr_arbiter2 u_arb (
        .CLK     (CLK),
        .RESET   (RESET),
        .req_a_i (A_REQ),
        .req_b_i (B_REQ),
        .en_i    (state_q == ST_IDLE),
        .grant_o (grant),
        .port_o  (gnt_port)
    );

    always_comb begin
        req_we    = (gnt_port == PORT_A) ? A_WE    : B_WE;
        req_addr  = (gnt_port == PORT_A) ? A_ADDR  : B_ADDR;
        req_wdata = (gnt_port == PORT_A) ? A_WDATA : B_WDATA;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (grant) state_d = req_we ? ST_WR_SETUP : ST_RD_ADDR;
            ST_RD_ADDR:   state_d = ST_RD_SAMPLE;
            ST_RD_SAMPLE: state_d = ST_DONE;
            ST_WR_SETUP:  state_d = ST_WR_STROBE;
            ST_WR_STROBE: state_d = ST_WR_HOLD;
            ST_WR_HOLD:   state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        stb_d = strobes_of(state_d);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_A;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            cs_q      <= 1'b0;
            oe_q      <= 1'b0;
            ws_q      <= 1'b0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cs_q     <= stb_d.cs;
            oe_q     <= stb_d.oe;
            ws_q     <= stb_d.ws;
            drive_q  <= stb_d.drive;
            busy_q   <= stb_d.busy;
            a_done_q <= (state_d == ST_DONE) && (port_q == PORT_A);
            b_done_q <= (state_d == ST_DONE) && (port_q == PORT_B);

            if (state_q == ST_IDLE && grant) begin
                port_q  <= gnt_port;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end

            // RAM has driven DATA for two cycles by the edge that leaves RD_SAMPLE.
            if (state_q == ST_RD_SAMPLE) begin
                if (port_q == PORT_A) begin
                    a_rdata_q <= DATA;
                end else begin
                    b_rdata_q <= DATA;
                end
            end
        end
    end

    assign DATA    = drive_q ? wdata_q : 'z;
    assign ADDR    = addr_q;
    assign RAM_CS  = cs_q;
    assign RAM_OE  = oe_q;
    assign WS      = ws_q;
    assign BUSY    = busy_q;
    assign A_DONE  = a_done_q;
    assign B_DONE  = b_done_q;
    assign A_RDATA = a_rdata_q;
    assign B_RDATA = b_rdata_q;

    a_bus_turnaround: assert property (@(posedge CLK) disable iff (RESET) !(cs_q && drive_q));
    a_done_exclusive: assert property (@(posedge CLK) disable iff (RESET) !(a_done_q && b_done_q));

endmodule
